// File: rtl/sine_nco_multi.sv
// Multi-channel sine NCO: one phase accumulator, NUM_CH equally spaced phase offsets,
// one shared quarter-wave table read round-robin, all lanes published together.
module sine_nco_multi #(
    parameter int NUM_CH = 3,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sync,
    input  logic [ACC_W-1:0]         phase_step,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int MAG_W = DATA_W - 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(NUM_CH + 3) + 1;
    localparam logic [ACC_W:0]    FULL_TURN = {1'b1, {ACC_W{1'b0}}};
    localparam logic [ACC_W-1:0]  CH_OFFSET = ACC_W'(FULL_TURN / (ACC_W + 1)'(NUM_CH));
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W - 1){1'b0}}};
    localparam real               HALF_PI   = 1.5707963267948966;

    // Quarter-wave magnitudes sampled at bin centres, built at elaboration time.
    logic [MAG_W-1:0] rom_table [DEPTH];
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam real ANGLE = HALF_PI * (real'(k) + 0.5) / real'(DEPTH);
        localparam int  MAG   = $rtoi(real'((2 ** MAG_W) - 1) * $sin(ANGLE) + 0.5);
        assign rom_table[k] = MAG_W'(MAG);
    end

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        ph_q, ph_d;
    logic                    rd_v_q, rd_v_d;
    logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [1:0]              rd_quad_q, rd_quad_d;
    logic                    dat_v_q, dat_v_d;
    logic [CH_W-1:0]         dat_ch_q, dat_ch_d;
    logic [1:0]              dat_quad_q, dat_quad_d;
    logic [MAG_W-1:0]        rom_q, rom_d;
    logic [DATA_W-1:0]       stage_q [NUM_CH];
    logic [DATA_W-1:0]       stage_d [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] data_out_q, data_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic [DATA_W-1:0]       recon;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ph_d        = ph_q;
        rd_v_d      = 1'b0;
        rd_ch_d     = rd_ch_q;
        rd_idx_d    = rd_idx_q;
        rd_quad_d   = rd_quad_q;
        dat_v_d     = rd_v_q;
        dat_ch_d    = rd_ch_q;
        dat_quad_d  = rd_quad_q;
        rom_d       = rom_table[rd_idx_q];
        stage_d     = stage_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;

        // Fold the magnitude back into offset-binary around mid-scale.
        recon = dat_quad_q[1] ? (MID - {1'b0, rom_q}) : (MID + {1'b0, rom_q});
        if (dat_v_q) begin
            stage_d[dat_ch_q] = recon;
        end

        if (en && busy_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    acc_d   = acc_q + phase_step;
                    ph_d    = acc_d;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                // One channel per cycle; mirror the index in odd quadrants.
                rd_v_d    = 1'b1;
                rd_ch_d   = CH_W'(cnt_q);
                rd_quad_d = ph_q[ACC_W-1 -: 2];
                rd_idx_d  = ph_q[ACC_W-3 -: IDX_W] ^ {IDX_W{ph_q[ACC_W-2]}};
                ph_d      = ph_q + CH_OFFSET;
                if (cnt_q == CNT_W'(NUM_CH - 1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(2)) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        data_out_d[i*DATA_W +: DATA_W] = stage_q[i];
                    end
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Resynchronisation dominates everything, including a same-cycle tick.
        if (sync) begin
            acc_d       = '0;
            state_d     = IDLE;
            cnt_d       = '0;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
            rd_v_d      = 1'b0;
            dat_v_d     = 1'b0;
            data_out_d  = data_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ph_q        <= '0;
            rd_v_q      <= 1'b0;
            rd_ch_q     <= '0;
            rd_idx_q    <= '0;
            rd_quad_q   <= '0;
            dat_v_q     <= 1'b0;
            dat_ch_q    <= '0;
            dat_quad_q  <= '0;
            rom_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= MID;
            end
            data_out_q  <= {NUM_CH{MID}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ph_q        <= ph_d;
            rd_v_q      <= rd_v_d;
            rd_ch_q     <= rd_ch_d;
            rd_idx_q    <= rd_idx_d;
            rd_quad_q   <= rd_quad_d;
            dat_v_q     <= dat_v_d;
            dat_ch_q    <= dat_ch_d;
            dat_quad_q  <= dat_quad_d;
            rom_q       <= rom_d;
            stage_q     <= stage_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
